// File: rtl/tdm_pkg.sv
// Shared types and constants for the 4-slot TDM demultiplexer.
package tdm_pkg;

    localparam int NUM_SLOTS = 4;

    typedef logic [1:0] slot_t;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_e;

endpackage

// File: rtl/tdm_slot_counter.sv
// Mod-4 slot index counter: clear wins over load-to-1, which wins over enable.
module tdm_slot_counter
    import tdm_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  en,
    input  logic  load1,
    input  logic  clr,
    output slot_t slot
);

    slot_t slot_q;
    slot_t slot_d;

    // Next slot index from the control inputs
    always_comb begin
        slot_d = slot_q;
        if (clr) begin
            slot_d = '0;
        end else if (load1) begin
            slot_d = slot_t'(1);
        end else if (en) begin
            slot_d = slot_q + slot_t'(1);
        end
    end

    // Slot register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign slot = slot_q;

endmodule

// File: rtl/tdm_demux4.sv
// Four-slot TDM demultiplexer with sync-based framing.
//
// state  | meaning
// -------+-----------------------------------------------------------
// HUNT   | not framed; waiting for a valid beat with sync=1
// LOCKED | framed; slot tells which slot the next valid beat fills
module tdm_demux4
    import tdm_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             sync,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] d,
    output logic             frame_valid,
    output logic [1:0]       slot,
    output logic             sync_err
);

    state_e state_q, state_d;

    // Slots 0..2 are held here until the slot-3 beat completes the frame.
    logic [WIDTH-1:0] sh0_q, sh0_d;
    logic [WIDTH-1:0] sh1_q, sh1_d;
    logic [WIDTH-1:0] sh2_q, sh2_d;

    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] c_q, c_d;
    logic [WIDTH-1:0] d_q, d_d;

    logic frame_valid_q, frame_valid_d;
    logic sync_err_q, sync_err_d;

    logic  cnt_en;
    logic  cnt_load1;
    logic  cnt_clr;
    slot_t slot_cur;

    tdm_slot_counter u_slot_counter (
        .clk   (clk),
        .reset (reset),
        .en    (cnt_en),
        .load1 (cnt_load1),
        .clr   (cnt_clr),
        .slot  (slot_cur)
    );

    // Framing FSM: next state, shadow capture, frame load and pulses
    always_comb begin
        state_d       = state_q;
        sh0_d         = sh0_q;
        sh1_d         = sh1_q;
        sh2_d         = sh2_q;
        a_d           = a_q;
        b_d           = b_q;
        c_d           = c_q;
        d_d           = d_q;
        frame_valid_d = 1'b0;
        sync_err_d    = 1'b0;
        cnt_en        = 1'b0;
        cnt_load1     = 1'b0;
        cnt_clr       = 1'b0;

        if (din_valid) begin
            unique case (state_q)
                HUNT: begin
                    if (sync) begin
                        sh0_d     = din;
                        cnt_load1 = 1'b1;
                        state_d   = LOCKED;
                    end
                end
                LOCKED: begin
                    if (sync) begin
                        // A sync mid-frame restarts the frame; the stale
                        // slots are simply overwritten as the new one fills.
                        sync_err_d = (slot_cur != slot_t'(0));
                        sh0_d      = din;
                        cnt_load1  = 1'b1;
                    end else begin
                        unique case (slot_cur)
                            2'd0: begin
                                sync_err_d = 1'b1;
                                cnt_clr    = 1'b1;
                                state_d    = HUNT;
                            end
                            2'd1: begin
                                sh1_d  = din;
                                cnt_en = 1'b1;
                            end
                            2'd2: begin
                                sh2_d  = din;
                                cnt_en = 1'b1;
                            end
                            default: begin
                                a_d           = sh0_q;
                                b_d           = sh1_q;
                                c_d           = sh2_q;
                                d_d           = din;
                                frame_valid_d = 1'b1;
                                cnt_en        = 1'b1;
                            end
                        endcase
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    // State, shadow, output and pulse registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= HUNT;
            sh0_q         <= '0;
            sh1_q         <= '0;
            sh2_q         <= '0;
            a_q           <= '0;
            b_q           <= '0;
            c_q           <= '0;
            d_q           <= '0;
            frame_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            sh0_q         <= sh0_d;
            sh1_q         <= sh1_d;
            sh2_q         <= sh2_d;
            a_q           <= a_d;
            b_q           <= b_d;
            c_q           <= c_d;
            d_q           <= d_d;
            frame_valid_q <= frame_valid_d;
            sync_err_q    <= sync_err_d;
        end
    end

    assign a           = a_q;
    assign b           = b_q;
    assign c           = c_q;
    assign d           = d_q;
    assign frame_valid = frame_valid_q;
    assign sync_err    = sync_err_q;
    assign slot        = slot_cur;

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed testbench for tdm_demux4 with a queue-based framing model.
module tb_tdm_demux4;
    localparam int W = 1;
    localparam int NSLOT = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] din = '0;
    logic         din_valid = 1'b0;
    logic         sync = 1'b0;
    logic [W-1:0] a, b, c, d;
    logic         frame_valid;
    logic [1:0]   slot;
    logic         sync_err;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    bit chk_en = 1'b0;
    int fv_t[$];

    tdm_demux4 #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .din         (din),
        .din_valid   (din_valid),
        .sync        (sync),
        .a           (a),
        .b           (b),
        .c           (c),
        .d           (d),
        .frame_valid (frame_valid),
        .slot        (slot),
        .sync_err    (sync_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Model: a frame is the list of beats collected since the last sync.
    logic [W-1:0] m_beats[$];
    bit           m_lock = 1'b0;
    logic [W-1:0] m_a = '0, m_b = '0, m_c = '0, m_d = '0;
    bit           m_fv = 1'b0, m_se = 1'b0;

    always @(posedge clk) begin
        m_fv = 1'b0;
        m_se = 1'b0;
        if (reset) begin
            m_beats.delete();
            m_lock = 1'b0;
            m_a = '0; m_b = '0; m_c = '0; m_d = '0;
        end else if (din_valid) begin
            if (sync) begin
                if (m_lock && m_beats.size() != 0) m_se = 1'b1;
                m_beats.delete();
                m_beats.push_back(din);
                m_lock = 1'b1;
            end else if (m_lock) begin
                if (m_beats.size() == 0) begin
                    m_se = 1'b1;
                    m_lock = 1'b0;
                end else begin
                    m_beats.push_back(din);
                    if (m_beats.size() == NSLOT) begin
                        m_a = m_beats[0];
                        m_b = m_beats[1];
                        m_c = m_beats[2];
                        m_d = m_beats[3];
                        m_fv = 1'b1;
                        m_beats.delete();
                    end
                end
            end
        end
    end

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Every-cycle compare against the model, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            cmp("model_a", 32'(a), 32'(m_a));
            cmp("model_b", 32'(b), 32'(m_b));
            cmp("model_c", 32'(c), 32'(m_c));
            cmp("model_d", 32'(d), 32'(m_d));
            cmp("model_frame_valid", 32'(frame_valid), 32'(m_fv));
            cmp("model_sync_err", 32'(sync_err), 32'(m_se));
            cmp("model_slot", 32'(slot), 32'(m_beats.size() % NSLOT));
            if (frame_valid === 1'b1) fv_t.push_back(cyc);
        end
    end

    task automatic beat(input logic [W-1:0] v, input logic s);
        din = v;
        sync = s;
        din_valid = 1'b1;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        sync = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_abcd(input string nm, input logic [3:0] exp);
        cmp(nm, 32'({a, b, c, d}), 32'(exp));
    endtask

    initial begin
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        idle(1);
        reset = 1'b0;
        chk_abcd("reset_abcd", 4'b0000);
        cmp("reset_slot", 32'(slot), 32'd0);
        cmp("reset_fv", 32'(frame_valid), 32'd0);

        // Basic frame 0,1,0,1
        beat(1'b0, 1'b1);
        beat(1'b1, 1'b0);
        beat(1'b0, 1'b0);
        beat(1'b1, 1'b0);
        chk_abcd("frame0101_abcd", 4'b0101);
        cmp("frame0101_fv", 32'(frame_valid), 32'd1);
        cmp("frame0101_se", 32'(sync_err), 32'd0);
        idle(1);
        cmp("frame0101_fv_drop", 32'(frame_valid), 32'd0);

        // Same frame with 3-cycle gaps between beats
        beat(1'b0, 1'b1);
        idle(3);
        cmp("gap_slot_hold", 32'(slot), 32'd1);
        beat(1'b1, 1'b0);
        idle(3);
        beat(1'b0, 1'b0);
        idle(3);
        cmp("gap_slot3", 32'(slot), 32'd3);
        cmp("gap_no_fv", 32'(frame_valid), 32'd0);
        beat(1'b1, 1'b0);
        cmp("gap_fv", 32'(frame_valid), 32'd1);
        chk_abcd("gap_abcd", 4'b0101);
        idle(2);

        // Sync arriving at slot 2 restarts the frame
        beat(1'b1, 1'b1);
        beat(1'b0, 1'b0);
        beat(1'b1, 1'b1);
        cmp("resync_se", 32'(sync_err), 32'd1);
        chk_abcd("resync_hold_abcd", 4'b0101);
        cmp("resync_slot", 32'(slot), 32'd1);
        beat(1'b1, 1'b0);
        cmp("resync_se_drop", 32'(sync_err), 32'd0);
        beat(1'b1, 1'b0);
        beat(1'b0, 1'b0);
        chk_abcd("resync_abcd", 4'b1110);
        idle(1);

        // Missing sync at slot 0 drops to HUNT
        beat(1'b1, 1'b0);
        cmp("lost_se", 32'(sync_err), 32'd1);
        repeat (4) beat(1'b1, 1'b0);
        chk_abcd("lost_abcd_hold", 4'b1110);
        cmp("lost_slot", 32'(slot), 32'd0);
        idle(1);

        // Reset mid-frame, colliding with a valid sync beat
        beat(1'b1, 1'b1);
        beat(1'b0, 1'b0);
        beat(1'b1, 1'b0);
        reset = 1'b1;
        din = 1'b1;
        sync = 1'b1;
        din_valid = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        din_valid = 1'b0;
        sync = 1'b0;
        chk_abcd("midreset_abcd", 4'b0000);
        cmp("midreset_slot", 32'(slot), 32'd0);
        fv_t.delete();
        repeat (3) beat(1'b1, 1'b0);
        idle(2);
        cmp("midreset_no_fv", 32'(fv_t.size()), 32'd0);

        // Back-to-back frames
        fv_t.delete();
        beat(1'b1, 1'b1);
        beat(1'b0, 1'b0);
        beat(1'b1, 1'b0);
        beat(1'b0, 1'b0);
        chk_abcd("b2b_first_abcd", 4'b1010);
        beat(1'b0, 1'b1);
        beat(1'b1, 1'b0);
        beat(1'b1, 1'b0);
        beat(1'b0, 1'b0);
        chk_abcd("b2b_second_abcd", 4'b0110);
        idle(2);
        cmp("b2b_fv_count", 32'(fv_t.size()), 32'd2);
        if (fv_t.size() == 2)
            cmp("b2b_fv_spacing", 32'(fv_t[1] - fv_t[0]), 32'd4);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
